// File: rtl/vm_router_layer_if.sv
// vm_router_layer_if: event control and StubsByLayer/VM/all-stubs memory bus of the VM router.
interface vm_router_layer_if #(parameter int VM_ADD_BITS = 4);
  logic                     en_proc;
  logic                     start;
  logic                     done;
  logic [5:0]               number_in;
  logic [5:0]               read_add;
  logic [35:0]              stub_in;
  logic [35:0]              stub_out;
  logic [3:0]               vm_wr_en;
  logic [4*VM_ADD_BITS-1:0] vm_add;
  logic                     allstub_wr_en;
  logic [5:0]               allstub_add;
  logic [3:0]               vm_overflow;
  modport master (
    input  en_proc, start, number_in, stub_in,
    output done, read_add, stub_out, vm_wr_en, vm_add, allstub_wr_en, allstub_add, vm_overflow
  );
  modport slave (
    output en_proc, start, number_in, stub_in,
    input  done, read_add, stub_out, vm_wr_en, vm_add, allstub_wr_en, allstub_add, vm_overflow
  );
endinterface

// File: rtl/vm_router_layer.sv
// vm_router_layer: walks one layer's StubsByLayer memory and steers each stub into one of four phi VM memories.
module vm_router_layer #(
  parameter int PHI_SEL_LSB = 26,
  parameter int VM_ADD_BITS = 4
) (
  input logic             clk,
  input logic             reset,
  vm_router_layer_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;
  localparam logic [VM_ADD_BITS-1:0] VM_MAX = '1;
  state_e                   state_q, state_d;
  logic [5:0]               n_q, n_d;
  logic [5:0]               read_add_q, read_add_d;
  logic [5:0]               as_cnt_q, as_cnt_d;
  logic [5:0]               allstub_add_q, allstub_add_d;
  logic                     v1_q, v1_d;
  logic                     done_q, done_d;
  logic                     as_wr_q, as_wr_d;
  logic [35:0]              stub_q, stub_d;
  logic [3:0]               wr_q, wr_d;
  logic [3:0]               full_q, full_d;
  logic [3:0]               ovf_q, ovf_d;
  logic [VM_ADD_BITS-1:0]   cnt_q [4];
  logic [VM_ADD_BITS-1:0]   cnt_d [4];
  logic [4*VM_ADD_BITS-1:0] vm_add_q, vm_add_d;
  logic [1:0]               sel;
  assign sel = bus.stub_in[PHI_SEL_LSB+1:PHI_SEL_LSB];
  // full_q marks a VM whose last slot was written; later stubs for it only overflow
  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    read_add_d    = read_add_q;
    as_cnt_d      = as_cnt_q;
    allstub_add_d = allstub_add_q;
    stub_d        = stub_q;
    full_d        = full_q;
    ovf_d         = ovf_q;
    cnt_d         = cnt_q;
    vm_add_d      = vm_add_q;
    v1_d          = 1'b0;
    done_d        = 1'b0;
    as_wr_d       = 1'b0;
    wr_d          = 4'b0;
    if (!bus.en_proc) begin
      state_d = IDLE;
    end else if (bus.start) begin
      n_d        = bus.number_in;
      read_add_d = 6'd0;
      as_cnt_d   = 6'd0;
      full_d     = 4'b0;
      ovf_d      = 4'b0;
      cnt_d      = '{default: '0};
      state_d    = (bus.number_in == 6'd0) ? IDLE : READ;
      done_d     = (bus.number_in == 6'd0);
    end else begin
      v1_d = (state_q == READ);
      if (v1_q) begin
        stub_d        = bus.stub_in;
        as_wr_d       = 1'b1;
        allstub_add_d = as_cnt_q;
        as_cnt_d      = as_cnt_q + 6'd1;
        if (full_q[sel]) begin
          ovf_d[sel] = 1'b1;
        end else begin
          wr_d[sel] = 1'b1;
          vm_add_d[sel*VM_ADD_BITS +: VM_ADD_BITS] = cnt_q[sel];
          if (cnt_q[sel] == VM_MAX) full_d[sel] = 1'b1;
          else cnt_d[sel] = cnt_q[sel] + 1'b1;
        end
      end
      if (state_q == READ) begin
        if (read_add_q == n_q - 6'd1) state_d = DRAIN;
        else read_add_d = read_add_q + 6'd1;
      end else if (state_q == DRAIN && !v1_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      n_q           <= 6'd0;
      read_add_q    <= 6'd0;
      as_cnt_q      <= 6'd0;
      allstub_add_q <= 6'd0;
      v1_q          <= 1'b0;
      done_q        <= 1'b0;
      as_wr_q       <= 1'b0;
      stub_q        <= 36'd0;
      wr_q          <= 4'b0;
      full_q        <= 4'b0;
      ovf_q         <= 4'b0;
      cnt_q         <= '{default: '0};
      vm_add_q      <= '0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      read_add_q    <= read_add_d;
      as_cnt_q      <= as_cnt_d;
      allstub_add_q <= allstub_add_d;
      v1_q          <= v1_d;
      done_q        <= done_d;
      as_wr_q       <= as_wr_d;
      stub_q        <= stub_d;
      wr_q          <= wr_d;
      full_q        <= full_d;
      ovf_q         <= ovf_d;
      cnt_q         <= cnt_d;
      vm_add_q      <= vm_add_d;
    end
  end
  assign bus.done          = done_q;
  assign bus.read_add      = read_add_q;
  assign bus.stub_out      = stub_q;
  assign bus.vm_wr_en      = wr_q;
  assign bus.vm_add        = vm_add_q;
  assign bus.allstub_wr_en = as_wr_q;
  assign bus.allstub_add   = allstub_add_q;
  assign bus.vm_overflow   = ovf_q;
endmodule

// File: tb/tb_vm_router_layer.sv
// tb_vm_router_layer: random events through the VM router, checked against a per-event list of expected writes.
module tb_vm_router_layer;
  localparam int VB = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [35:0] mem [64];
  int n_cmp = 0;
  int n_err = 0;
  int pat [5] = '{0, 1, 1, 3, 2};
  vm_router_layer_if #(.VM_ADD_BITS(VB)) bus ();
  vm_router_layer #(.PHI_SEL_LSB(26), .VM_ADD_BITS(VB)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.stub_in <= mem[bus.read_add];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_wr"}, bus.vm_wr_en, 0);
    check({tag, "_as_wr"}, bus.allstub_wr_en, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask
  // Called at a negedge; start is high for the following edge T. Returns at the negedge of cycle stop_at
  // (0 = run to the done cycle) so the caller may act in that same cycle.
  task automatic run_event(input int n, input int mode, input int stop_at);
    int cnt [4];
    int sel [64];
    int vadd [64];
    bit wr [64];
    logic [3:0] ovf;
    int last;
    int k;
    ovf = 4'b0;
    cnt = '{default: 0};
    for (int i = 0; i < n; i++) begin
      logic [35:0] s;
      sel[i] = mode == 1 ? 2 : mode == 2 ? pat[i] : int'($urandom_range(0, 3));
      s = 36'({$urandom(), $urandom()});
      s[27:26] = 2'(sel[i]);
      mem[i] = s;
      vadd[i] = cnt[sel[i]];
      wr[i] = cnt[sel[i]] < (1 << VB);
      if (!wr[i]) ovf[sel[i]] = 1'b1;
      cnt[sel[i]]++;
    end
    bus.number_in = 6'(n);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    last = n == 0 ? 1 : n + 3;
    for (int c = 1; c <= last; c++) begin
      if (c > 1) @(negedge clk);
      check($sformatf("done_c%0d", c), bus.done, c == last);
      if (c <= n) check($sformatf("read_add_c%0d", c), bus.read_add, c - 1);
      if (c == 1) check("ovf_clear", bus.vm_overflow, 0);
      if (c >= 3 && c <= n + 2) begin
        k = c - 3;
        check($sformatf("vm_wr_en_k%0d", k), bus.vm_wr_en, wr[k] ? (1 << sel[k]) : 0);
        check($sformatf("as_wr_k%0d", k), bus.allstub_wr_en, 1);
        check($sformatf("as_add_k%0d", k), bus.allstub_add, k);
        check($sformatf("stub_out_k%0d", k), bus.stub_out, mem[k]);
        if (wr[k]) check($sformatf("vm_add_k%0d", k), bus.vm_add[sel[k]*VB +: VB], vadd[k]);
      end else begin
        check($sformatf("no_wr_c%0d", c), bus.vm_wr_en, 0);
        check($sformatf("no_as_wr_c%0d", c), bus.allstub_wr_en, 0);
      end
      if (c == stop_at) return;
    end
    check("vm_overflow", bus.vm_overflow, ovf);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end
  initial begin
    bus.en_proc = 1'b1;
    bus.start = 1'b0;
    bus.number_in = 6'd0;
    for (int i = 0; i < 64; i++) mem[i] = 36'd0;
    repeat (3) @(negedge clk);
    check("rst_stub_out", bus.stub_out, 0);
    check("rst_vm_add", bus.vm_add, 0);
    check("rst_read_add", bus.read_add, 0);
    check("rst_ovf", bus.vm_overflow, 0);
    check_quiet("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("post_rst");
    run_event(5, 2, 0);
    run_event(0, 0, 0);
    run_event(0, 0, 0);
    run_event(20, 1, 0);
    run_event(7, 0, 0);
    repeat (8) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_event(int'($urandom_range(1, 40)), 0, 0);
    end
    run_event(63, 0, 0);
    run_event(10, 0, 4);
    run_event(6, 0, 0);
    run_event(10, 0, 3);
    bus.en_proc = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_quiet("en_proc_low");
    end
    check("en_proc_read_add_hold", bus.read_add, 2);
    bus.en_proc = 1'b1;
    @(negedge clk);
    run_event(4, 0, 0);
    run_event(10, 0, 4);
    #2 reset = 1'b0;
    #1;
    check("arst_stub_out", bus.stub_out, 0);
    check("arst_read_add", bus.read_add, 0);
    check("arst_vm_add", bus.vm_add, 0);
    check("arst_as_add", bus.allstub_add, 0);
    check_quiet("arst");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_quiet("after_arst");
    end
    run_event(9, 0, 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
